// File: rtl/counter_control.sv
// Sequencer for an up/down counter datapath: clear, count up to max, count back
// down to zero, flag completion, optionally repeat. One count step per TICK_DIV cycles.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start; all strobes low
// CLEAR | one-cycle clear strobe to the datapath counter
// UP    | increment on each prescaler tick until the max flag
// DOWN  | decrement on each prescaler tick until the zero flag
// DONE  | one-cycle completion pulse, then repeat or return to IDLE
module counter_control #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic stop,
  input  logic loop,
  input  logic z,
  input  logic m,
  output logic op,
  output logic c_ld,
  output logic c_clr,
  output logic busy,
  output logic done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_UP,
    S_DOWN,
    S_DONE
  } state_t;

  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] presc;
  logic [15:0] presc_nxt;
  logic        loop_r;
  logic        counting;
  logic        tick;
  logic        accept;

  assign counting = (state == S_UP) || (state == S_DOWN);
  assign tick     = counting && (presc == PRESC_LAST);
  assign accept   = (state == S_IDLE) && start && !stop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      presc  <= '0;
      loop_r <= 1'b0;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
      if (accept) begin
        loop_r <= loop;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_UP;
      S_UP:    if (tick && m) state_nxt = S_DOWN;
      S_DOWN:  if (tick && z) state_nxt = S_DONE;
      S_DONE:  state_nxt = loop_r ? S_CLEAR : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (stop && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
    end
  end

  // Prescaler restarts on every UP->DOWN turn since that turn happens on a tick.
  always_comb begin
    presc_nxt = '0;
    if (counting && !stop && !tick) begin
      presc_nxt = presc + 16'd1;
    end
  end

  // Strobes are masked in an abort cycle so the datapath counter keeps its value.
  always_comb begin
    op    = (state == S_DOWN);
    busy  = (state != S_IDLE);
    c_clr = (state == S_CLEAR) && !stop;
    done  = (state == S_DONE) && !stop;
    c_ld  = 1'b0;
    if (!stop && tick) begin
      c_ld = ((state == S_UP) && !m) || ((state == S_DOWN) && !z);
    end
  end

endmodule

// File: tb/tb_counter_control.sv
// Bench for counter_control: vector table, hand-written corner sequences and a
// randomized run checked against a queue-based model of the expected strobe stream.
module tb_counter_control;

  typedef logic [4:0] exp_q_t[$];  // {busy, op, c_ld, c_clr, done}

  typedef struct {
    int         mx;
    logic       start;
    logic       stop;
    logic       loop;
    logic [4:0] exp;
  } vec_t;

  localparam logic [4:0] E_IDLE = 5'b00000;
  localparam logic [4:0] E_CLR  = 5'b10010;
  localparam logic [4:0] E_UPLD = 5'b10100;
  localparam logic [4:0] E_UPNL = 5'b10000;
  localparam logic [4:0] E_DNLD = 5'b11100;
  localparam logic [4:0] E_DNNL = 5'b11000;
  localparam logic [4:0] E_DONE = 5'b10001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, stop, loop, start4, stop4, loop4;
  logic z1, m1, op1, ld1, clr1, busy1, done1;
  logic z4, m4, op4, ld4, clr4, busy4, done4;
  int   max1 = 0, max4 = 0, cnt1 = 0, cnt4 = 0;
  int   n_cmp = 0, n_bad = 0;

  vec_t   vecs[$];
  exp_q_t mq[2];
  logic   lr[2];
  int     dv[2] = '{1, 4};

  counter_control #(.TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop), .z(z1), .m(m1),
    .op(op1), .c_ld(ld1), .c_clr(clr1), .busy(busy1), .done(done1));

  counter_control #(.TICK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .stop(stop4), .loop(loop4), .z(z4), .m(m4),
    .op(op4), .c_ld(ld4), .c_clr(clr4), .busy(busy4), .done(done4));

  // Datapath counters driven by the controllers' strobes.
  assign z1 = (cnt1 == 0);
  assign m1 = (cnt1 == max1);
  assign z4 = (cnt4 == 0);
  assign m4 = (cnt4 == max4);

  always @(posedge clk) begin
    if (clr1) cnt1 <= 0;
    else if (ld1) cnt1 <= op1 ? cnt1 - 1 : cnt1 + 1;
    if (clr4) cnt4 <= 0;
    else if (ld4) cnt4 <= op4 ? cnt4 - 1 : cnt4 + 1;
  end

  function automatic logic [4:0] vec1();
    return {busy1, op1, ld1, clr1, done1};
  endfunction

  function automatic logic [4:0] vec4();
    return {busy4, op4, ld4, clr4, done4};
  endfunction

  function automatic void check5(string name, logic [4:0] act, logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b ({busy,op,c_ld,c_clr,done})", name, act, exp);
    end
  endfunction

  function automatic void checki(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void add(int mx, logic st, logic sp, logic lp, logic [4:0] e);
    vec_t v;
    v.mx = mx; v.start = st; v.stop = sp; v.loop = lp; v.exp = e;
    vecs.push_back(v);
  endfunction

  // Full run from the clear cycle through done: max+1 steps each way, TICK_DIV cycles per step.
  function automatic exp_q_t gen_run(int d, int mx);
    exp_q_t q;
    q.push_back(E_CLR);
    for (int s = 0; s <= mx; s++)
      for (int j = 0; j < d; j++) q.push_back((j == d - 1 && s < mx) ? E_UPLD : E_UPNL);
    for (int s = 0; s <= mx; s++)
      for (int j = 0; j < d; j++) q.push_back((j == d - 1 && s < mx) ? E_DNLD : E_DNNL);
    q.push_back(E_DONE);
    return q;
  endfunction

  function automatic logic [4:0] model_step(int k, int mx, logic st, logic sp, logic lp);
    logic [4:0] e;
    if (mq[k].size() == 0) begin
      e = E_IDLE;
      if (st && !sp) begin
        mq[k] = gen_run(dv[k], mx);
        lr[k] = lp;
      end
    end else begin
      e = mq[k].pop_front();
      if (sp) begin
        e[2:0] = 3'b000;
        mq[k].delete();
      end else if (mq[k].size() == 0 && lr[k]) begin
        mq[k] = gen_run(dv[k], mx);
      end
    end
    return e;
  endfunction

  initial begin
    int         found, n_ev, c;
    int         ld_at[$];
    int         done_at;
    logic       st, sp, lp;
    logic [4:0] e1, e4;

    reset = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
    start4 = 1'b0; stop4 = 1'b0; loop4 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check5("reset_dut1", vec1(), E_IDLE);
    check5("reset_dut4", vec4(), E_IDLE);
    @(negedge clk);
    reset = 1'b1;

    // start+stop together in IDLE, full max=3 run with start/loop noise while busy, then max=0.
    add(3, 1, 1, 1, E_IDLE); add(3, 0, 0, 0, E_IDLE);
    add(3, 1, 0, 0, E_IDLE); add(3, 0, 0, 1, E_CLR);
    add(3, 1, 0, 1, E_UPLD); add(3, 0, 0, 0, E_UPLD); add(3, 0, 0, 0, E_UPLD);
    add(3, 0, 0, 0, E_UPNL);
    add(3, 1, 0, 0, E_DNLD); add(3, 0, 0, 1, E_DNLD); add(3, 1, 0, 0, E_DNLD);
    add(3, 0, 0, 0, E_DNNL); add(3, 0, 0, 1, E_DONE);
    add(3, 0, 0, 0, E_IDLE); add(3, 0, 0, 0, E_IDLE);
    add(0, 1, 0, 0, E_IDLE); add(0, 0, 0, 0, E_CLR); add(0, 0, 0, 0, E_UPNL);
    add(0, 0, 0, 0, E_DNNL); add(0, 0, 0, 0, E_DONE); add(0, 0, 0, 0, E_IDLE);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      max1 = vecs[i].mx; start = vecs[i].start; stop = vecs[i].stop; loop = vecs[i].loop;
      #1;
      check5($sformatf("vec%0d", i), vec1(), vecs[i].exp);
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b0; loop = 1'b0;

    // TICK_DIV=4, max=2: c_ld every 4 cycles, first one 4 cycles after the clear cycle.
    max4 = 2;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    #1;
    check5("div4_clear", vec4(), E_CLR);
    done_at = -1;
    for (c = 1; c < 40; c++) begin
      @(negedge clk); #1;
      if (ld4) ld_at.push_back(c);
      if (done4 && done_at < 0) done_at = c;
    end
    checki("div4_ld_count", ld_at.size(), 4);
    if (ld_at.size() == 4) begin
      checki("div4_ld0", ld_at[0], 4);
      checki("div4_ld1", ld_at[1], 8);
      checki("div4_ld2", ld_at[2], 16);
      checki("div4_ld3", ld_at[3], 20);
    end
    checki("div4_done", done_at, 25);
    checki("div4_idle", int'(busy4), 0);

    // Loop mode repeats; stop in UP at count 1 aborts without touching the counter.
    max1 = 2;
    @(negedge clk); start = 1'b1; loop = 1'b1;
    @(negedge clk); start = 1'b0; loop = 1'b0;
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      @(negedge clk); #1;
      if (done1) found = 1;
    end
    checki("loop_done_seen", found, 1);
    @(negedge clk); #1;
    check5("loop_reclear", vec1(), E_CLR);
    @(negedge clk); #1;
    check5("loop_up_first", vec1(), E_UPLD);
    @(negedge clk); stop = 1'b1; #1;
    checki("stop_cnt_before", cnt1, 1);
    check5("stop_strobes_masked", vec1(), E_UPNL);
    @(negedge clk); stop = 1'b0; #1;
    check5("stop_idle", vec1(), E_IDLE);
    n_ev = 0;
    repeat (12) begin
      @(negedge clk); #1;
      if (busy1 || done1 || ld1 || clr1) n_ev++;
    end
    checki("stop_quiet", n_ev, 0);
    checki("stop_cnt_kept", cnt1, 1);

    // Asynchronous reset between edges while in DOWN.
    max1 = 3;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk); #1;
      if (op1) found = 1;
    end
    checki("reach_down", found, 1);
    check5("down_before_reset", vec1(), E_DNLD);
    #2 reset = 1'b0;
    #1 check5("async_reset_drop", vec1(), E_IDLE);
    @(negedge clk); #1;
    check5("reset_held", vec1(), E_IDLE);
    reset = 1'b1;
    n_ev = 0;
    repeat (8) begin
      @(negedge clk); #1;
      if (busy1 || done1 || ld1 || clr1 || op1) n_ev++;
    end
    checki("no_resume", n_ev, 0);

    // Randomized traffic on both instances against the stream model.
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      start = 1'b0; stop = 1'b1; loop = 1'b0;
      start4 = 1'b0; stop4 = 1'b1; loop4 = 1'b0;
      #1;
      check5($sformatf("rnd_flush1_%0d", b), vec1(), model_step(0, max1, 1'b0, 1'b1, 1'b0));
      check5($sformatf("rnd_flush4_%0d", b), vec4(), model_step(1, max4, 1'b0, 1'b1, 1'b0));
      @(negedge clk);
      max1 = b; max4 = b % 3;
      stop = 1'b0; stop4 = 1'b0;
      #1;
      check5($sformatf("rnd_idle1_%0d", b), vec1(), model_step(0, max1, 1'b0, 1'b0, 1'b0));
      check5($sformatf("rnd_idle4_%0d", b), vec4(), model_step(1, max4, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        st = ($urandom_range(0, 3) == 0);
        sp = ($urandom_range(0, 39) == 0);
        lp = 1'($urandom_range(0, 1));
        start = st; stop = sp; loop = lp;
        start4 = st; stop4 = sp; loop4 = lp;
        #1;
        e1 = model_step(0, max1, st, sp, lp);
        e4 = model_step(1, max4, st, sp, lp);
        check5($sformatf("rnd1_b%0d_c%0d", b, i), vec1(), e1);
        check5($sformatf("rnd4_b%0d_c%0d", b, i), vec4(), e4);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
